// File: rtl/dmem_io.sv
// dmem_io: data-memory and memory-mapped I/O block for a single-cycle
// processor datapath.
//
// Address map (word-decoded on aluout[31:2], byte offset ignored):
//   aluout < 4*RAM_WORDS : data RAM, one 32-bit word per entry
//   0x0000FF00           : CYCLE  - free-running 32-bit counter (writable)
//   0x0000FF04           : TXDATA - write pushes writedata[7:0] to TX FIFO
//   0x0000FF08           : STATUS - {count[15:8], overflow[2], full[1], empty[0]}
//   anything else        : reads 0, writes ignored
//
// Ports:
//   clk        - single clock, rising-edge state updates
//   reset      - asynchronous, active-low reset
//   memwrite   - store enable from the processor
//   aluout     - byte address from the ALU
//   writedata  - store data
//   readdata   - combinational load data (zero-cycle latency)
//   out_data   - TX FIFO head byte (0 while the FIFO is empty)
//   out_valid  - TX FIFO not empty
//   out_ready  - consumer accepts out_data this cycle
module dmem_io #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4    // power of two, 2..16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;

  localparam logic [29:0] CYCLE_WADDR  = 30'h0000_3FC0;
  localparam logic [29:0] TXDATA_WADDR = 30'h0000_3FC1;
  localparam logic [29:0] STATUS_WADDR = 30'h0000_3FC2;

  // ---------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------
  logic [29:0]       waddr;
  logic [RAM_AW-1:0] ram_idx;
  logic              is_ram;
  logic              is_cycle;
  logic              is_tx;
  logic              is_status;
  logic              unused_addr_bits;

  assign waddr     = aluout[31:2];
  assign ram_idx   = waddr[RAM_AW-1:0];
  assign is_ram    = (32'(waddr) < 32'(RAM_WORDS));
  // RAM takes priority so an oversized RAM can never alias a register.
  assign is_cycle  = !is_ram && (waddr == CYCLE_WADDR);
  assign is_tx     = !is_ram && (waddr == TXDATA_WADDR);
  assign is_status = !is_ram && (waddr == STATUS_WADDR);
  assign unused_addr_bits = &{1'b0, aluout[1:0]};

  // ---------------------------------------------------------------
  // Data RAM: asynchronous read for the single-cycle datapath,
  // contents deliberately not reset.
  // ---------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (memwrite && is_ram) begin
      ram[ram_idx] <= writedata;
    end
  end

  // ---------------------------------------------------------------
  // CYCLE counter
  // ---------------------------------------------------------------
  logic [31:0] cycle_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_reg <= '0;
    end else if (memwrite && is_cycle) begin
      cycle_reg <= writedata;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
    end
  end

  // ---------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] rptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          ovf_set;
  logic          ovf_clr;

  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign push       = memwrite && is_tx;
  assign pop        = out_valid && out_ready;
  // A push into a full FIFO still succeeds when a pop frees a slot
  // on the same edge.
  assign push_ok    = push && (!fifo_full || pop);
  assign ovf_set    = push && fifo_full && !pop;
  assign ovf_clr    = memwrite && is_status && writedata[2];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wptr_reg] <= writedata[7:0];
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr_reg <= wptr_reg + PW'(1);
      end
      if (pop) begin
        rptr_reg <= rptr_reg + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // Set has priority over a simultaneous clear.
      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  // Head byte is gated by valid so out_data is 0 whenever the FIFO is
  // empty, including throughout reset, without resetting the storage.
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_mem[rptr_reg] : 8'h00;

  // ---------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------
  logic [31:0] status_word;

  assign status_word = {16'h0000, 8'(count_reg), 5'b00000, ovf_reg, fifo_full, fifo_empty};

  always_comb begin
    readdata = '0;
    if (is_ram) begin
      readdata = ram[ram_idx];
    end else if (is_cycle) begin
      readdata = cycle_reg;
    end else if (is_status) begin
      readdata = status_word;
    end
  end

endmodule

// File: tb/tb_dmem_io.sv
// Testbench for dmem_io: a fixed vector table for the directed
// scenarios, hand-written multi-cycle sequences for reset and counter
// wrap, and randomized traffic checked against a queue-based model.
module tb_dmem_io;

  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 4;

  localparam logic [31:0] A_CYCLE  = 32'h0000_FF00;
  localparam logic [31:0] A_TX     = 32'h0000_FF04;
  localparam logic [31:0] A_STATUS = 32'h0000_FF08;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] aluout = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  dmem_io #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .aluout   (aluout),
    .writedata(writedata),
    .readdata (readdata),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [int];
  logic [31:0] m_cycle;
  logic [7:0]  m_fifo [$];
  logic        m_ovf;

  task automatic model_reset();
    m_cycle = '0;
    m_fifo.delete();
    m_ovf = 1'b0;
  endtask

  // Expected load value; known=0 for RAM words never written.
  task automatic model_read(input logic [31:0] a, output logic known, output logic [31:0] v);
    int unsigned w;
    int          n;
    w = a >> 2;
    n = m_fifo.size();
    known = 1'b1;
    v = '0;
    if (w < RAM_WORDS) begin
      if (m_ram.exists(int'(w))) v = m_ram[int'(w)];
      else known = 1'b0;
    end else if (a[31:2] == A_CYCLE[31:2]) begin
      v = m_cycle;
    end else if (a[31:2] == A_STATUS[31:2]) begin
      v = 32'(n) << 8;
      if (n == 0) v[0] = 1'b1;
      if (n == FIFO_DEPTH) v[1] = 1'b1;
      v[2] = m_ovf;
    end
  endtask

  task automatic model_clock(input logic mw, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    int unsigned w;
    logic push, pop, dropped;
    w = a >> 2;
    push = mw && (w >= RAM_WORDS) && (a[31:2] == A_TX[31:2]);
    pop  = (m_fifo.size() != 0) && rdy;
    dropped = 1'b0;
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(wd[7:0]);
      else dropped = 1'b1;
    end
    if (mw && (w >= RAM_WORDS) && (a[31:2] == A_STATUS[31:2]) && wd[2]) m_ovf = 1'b0;
    if (dropped) m_ovf = 1'b1;
    if (mw && (w >= RAM_WORDS) && (a[31:2] == A_CYCLE[31:2])) m_cycle = wd;
    else m_cycle = m_cycle + 32'd1;
    if (mw && w < RAM_WORDS) m_ram[int'(w)] = wd;
  endtask

  // ---------------- stimulus primitives ----------------
  logic [31:0] cur_rd;
  logic        cur_ov;
  logic [7:0]  cur_od;

  // One bus cycle: drive at negedge, sample before the posedge,
  // compare against the model, then advance the model with the edge.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    logic        known;
    logic [31:0] e;
    @(negedge clk);
    memwrite = mw; aluout = a; writedata = wd; out_ready = rdy;
    #1;
    cur_rd = readdata; cur_ov = out_valid; cur_od = out_data;
    model_read(a, known, e);
    if (known) check("model_readdata", cur_rd, e);
    check("model_out_valid", 32'(cur_ov), 32'(m_fifo.size() != 0));
    check("model_out_data", 32'(cur_od), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'h0);
    @(posedge clk);
    model_clock(mw, a, wd, rdy);
  endtask

  // Assert reset just after a negedge, check the asynchronous clear,
  // hold it across one rising edge and release after that edge.
  task automatic do_reset();
    @(negedge clk);
    memwrite = 1'b0; aluout = A_STATUS; out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_status", readdata, 32'h0000_0001);
    aluout = A_CYCLE;
    #1;
    check("rst_cycle", readdata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_ov;
    logic [7:0]  exp_od;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic mw, input logic [31:0] addr, input logic [31:0] wd, input logic rdy,
                     input logic chk_rd, input logic [31:0] exp_rd, input logic exp_ov, input logic [7:0] exp_od);
    vec_t v;
    v.mw = mw; v.addr = addr; v.wd = wd; v.rdy = rdy;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_ov = exp_ov; v.exp_od = exp_od;
    tbl.push_back(v);
  endtask

  initial begin : main
    logic [31:0] a;
    logic [31:0] wd;
    logic        mw;
    logic        rdy;
    int unsigned sel;

    // RAM write/read with byte-offset aliasing and an unmapped read
    add(1, 32'h04, 32'hCAFEBABE, 0, 0, 32'h0, 0, 8'h00);
    add(0, 32'h04, 32'h0, 0, 1, 32'hCAFEBABE, 0, 8'h00);
    add(0, 32'h07, 32'h0, 0, 1, 32'hCAFEBABE, 0, 8'h00);
    add(0, 32'h100, 32'h0, 0, 1, 32'h0, 0, 8'h00);
    // Overfill with the consumer stalled, then drain in order
    add(1, A_TX, 32'h11, 0, 1, 32'h0, 0, 8'h00);
    add(1, A_TX, 32'h22, 0, 1, 32'h0, 1, 8'h11);
    add(1, A_TX, 32'h33, 0, 1, 32'h0, 1, 8'h11);
    add(1, A_TX, 32'h44, 0, 1, 32'h0, 1, 8'h11);
    add(1, A_TX, 32'h55, 0, 1, 32'h0, 1, 8'h11);
    add(0, A_STATUS, 32'h0, 0, 1, 32'h0406, 1, 8'h11);
    add(0, A_STATUS, 32'h0, 1, 1, 32'h0406, 1, 8'h11);
    add(0, A_STATUS, 32'h0, 1, 1, 32'h0304, 1, 8'h22);
    add(0, A_STATUS, 32'h0, 1, 1, 32'h0204, 1, 8'h33);
    add(0, A_STATUS, 32'h0, 1, 1, 32'h0104, 1, 8'h44);
    add(0, A_STATUS, 32'h0, 1, 1, 32'h0005, 0, 8'h00);
    // Clear overflow through STATUS
    add(1, A_STATUS, 32'h4, 0, 1, 32'h0005, 0, 8'h00);
    add(0, A_STATUS, 32'h0, 0, 1, 32'h0001, 0, 8'h00);
    // Full FIFO with simultaneous push and pop
    add(1, A_TX, 32'hA1, 0, 1, 32'h0, 0, 8'h00);
    add(1, A_TX, 32'hA2, 0, 1, 32'h0, 1, 8'hA1);
    add(1, A_TX, 32'hA3, 0, 1, 32'h0, 1, 8'hA1);
    add(1, A_TX, 32'hA4, 0, 1, 32'h0, 1, 8'hA1);
    add(0, A_STATUS, 32'h0, 0, 1, 32'h0402, 1, 8'hA1);
    add(1, A_TX, 32'h99, 1, 1, 32'h0, 1, 8'hA1);
    add(0, A_STATUS, 32'h0, 0, 1, 32'h0402, 1, 8'hA2);
    add(0, A_STATUS, 32'h0, 1, 1, 32'h0402, 1, 8'hA2);
    add(0, A_STATUS, 32'h0, 1, 1, 32'h0300, 1, 8'hA3);
    add(0, A_STATUS, 32'h0, 1, 1, 32'h0200, 1, 8'hA4);
    add(0, A_STATUS, 32'h0, 1, 1, 32'h0100, 1, 8'h99);
    add(0, A_STATUS, 32'h0, 0, 1, 32'h0001, 0, 8'h00);

    model_reset();
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].mw, tbl[i].addr, tbl[i].wd, tbl[i].rdy);
      $display("vec %0d: mw=%0d addr=0x%08h wd=0x%08h rdy=%0d -> rd=0x%08h ov=%0d od=0x%02h",
               i, tbl[i].mw, tbl[i].addr, tbl[i].wd, tbl[i].rdy, cur_rd, cur_ov, cur_od);
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_readdata", i), cur_rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_out_valid", i), 32'(cur_ov), 32'(tbl[i].exp_ov));
      check($sformatf("tbl%0d_out_data", i), 32'(cur_od), 32'(tbl[i].exp_od));
    end

    // Counter: ten cycles after release, then load and wrap
    do_reset();
    repeat (10) step(0, 32'h200, 32'h0, 0);
    step(0, A_CYCLE, 32'h0, 0);
    $display("seq cycle: after 10 cycles rd=0x%08h", cur_rd);
    check("cycle_after_10", cur_rd, 32'd10);
    step(1, A_CYCLE, 32'hFFFF_FFFE, 0);
    step(0, A_CYCLE, 32'h0, 0);
    $display("seq cycle: after load rd=0x%08h", cur_rd);
    check("cycle_loaded", cur_rd, 32'hFFFF_FFFE);
    step(0, A_CYCLE, 32'h0, 0);
    check("cycle_max", cur_rd, 32'hFFFF_FFFF);
    step(0, A_CYCLE, 32'h0, 0);
    $display("seq cycle: after wrap rd=0x%08h", cur_rd);
    check("cycle_wrap", cur_rd, 32'h0);

    // Reset mid-stream discards FIFO contents
    step(1, A_TX, 32'h61, 0);
    step(1, A_TX, 32'h62, 0);
    step(1, A_TX, 32'h63, 0);
    step(0, A_STATUS, 32'h0, 0);
    check("pre_reset_status", cur_rd, 32'h0300);
    do_reset();
    step(0, A_CYCLE, 32'h0, 0);
    $display("seq reset: first cycle after release CYCLE=0x%08h", cur_rd);
    check("post_reset_cycle", cur_rd, 32'h0);
    step(0, A_STATUS, 32'h0, 1);
    $display("seq reset: STATUS=0x%08h", cur_rd);
    check("post_reset_status", cur_rd, 32'h0001);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: a = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
        3:       a = A_CYCLE | 32'($urandom_range(0, 3));
        4, 5, 6: a = A_TX | 32'($urandom_range(0, 3));
        7:       a = A_STATUS | 32'($urandom_range(0, 3));
        8:       a = 32'h8000_FF00 | (32'($urandom_range(0, 2)) << 2);
        default: a = (sel == 9 && ($urandom & 1)) ? 32'h0000_FF0C : 32'h0000_0100 + 32'($urandom_range(0, 255));
      endcase
      wd  = $urandom;
      mw  = ($urandom_range(0, 1) == 1);
      rdy = (i < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      step(mw, a, wd, rdy);
      $display("rnd %0d: mw=%0d addr=0x%08h wd=0x%08h rdy=%0d -> rd=0x%08h ov=%0d od=0x%02h",
               i, mw, a, wd, rdy, cur_rd, cur_ov, cur_od);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
